// File: rtl/k10_smoke_pkg.sv
// Shared types and helpers for the smoke monitor: FSM states, verdict codes
// and a lowest-set-bit search used to report the offending channel.
package k10_smoke_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } smoke_state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'b00,
    FAIL_TIMEOUT = 2'b01,
    FAIL_ORDER   = 2'b10,
    FAIL_UNEXP   = 2'b11
  } smoke_fail_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/k10_sync_edge.sv
// Two-flop synchroniser per bit with a registered rising-edge output. Asserting
// load_i discards any pending edge so only edges after the baseline count.
module k10_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_q;
    logic sync_q;
    logic base_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
        base_q <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        meta_q <= async_i[gi];
        sync_q <= meta_q;
        base_q <= sync_q;
        rise_q <= load_i ? 1'b0 : (sync_q & ~base_q);
      end
    end

    assign level_o[gi] = sync_q;
    assign rise_o[gi]  = rise_q;
  end

endmodule

// File: rtl/k10_smoke_monitor.sv
// Sticky pass/fail monitor: every masked channel must assert within a cycle
// budget, optionally in ascending order and with no activity on other channels.
module k10_smoke_monitor
  import k10_smoke_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int EDGE_MODE      = 1,
  parameter int ORDERED        = 0,
  parameter int STRICT         = 0,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_CH-1:0] expect_mask_i,
  input  logic [NUM_CH-1:0] gp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [1:0]        fail_code_o,
  output logic [CH_W-1:0]   fail_ch_o,
  output logic [NUM_CH-1:0] seen_o,
  output logic [CNT_W-1:0]  cycles_o
);

  smoke_state_e      state_q, state_d;
  smoke_fail_e       code_q, code_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic [NUM_CH-1:0] level, rise, evt, new_w, unexp, pend, viol, seen_nx, missing;
  logic              complete;

  k10_sync_edge #(.WIDTH(NUM_CH)) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (state_q == ST_ARM),
    .async_i (gp_i),
    .level_o (level),
    .rise_o  (rise)
  );

  assign evt      = (EDGE_MODE != 0) ? rise : level;
  assign new_w    = evt & mask_q & ~seen_q;
  assign unexp    = evt & ~mask_q;
  assign pend     = mask_q & ~seen_q & ~new_w;
  assign seen_nx  = seen_q | new_w;
  assign missing  = mask_q & ~seen_nx;
  assign complete = (seen_nx == mask_q);

  // A new bit is out of order if a still-pending masked bit sits below it.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_viol
    if (gi == 0) begin : g_lsb
      assign viol[gi] = 1'b0;
    end else begin : g_upper
      assign viol[gi] = new_w[gi] & (|pend[gi-1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    ch_d    = ch_q;
    if (abort_i) begin
      state_d = ST_IDLE;
      mask_d  = '0;
      seen_d  = '0;
      cnt_d   = '0;
      code_d  = FAIL_NONE;
      ch_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start_i) begin
            mask_d  = expect_mask_i;
            seen_d  = '0;
            cnt_d   = '0;
            code_d  = FAIL_NONE;
            ch_d    = '0;
            state_d = (expect_mask_i == '0) ? ST_PASS : ST_ARM;
          end
        end
        ST_ARM: state_d = ST_RUN;
        ST_RUN: begin
          seen_d = seen_nx;
          if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_d = cnt_q + 1'b1;
          if ((STRICT != 0) && (|unexp)) begin
            state_d = ST_FAIL;
            code_d  = FAIL_UNEXP;
            ch_d    = CH_W'(lowest_set(32'(unexp)));
          end else if ((ORDERED != 0) && (|viol)) begin
            state_d = ST_FAIL;
            code_d  = FAIL_ORDER;
            ch_d    = CH_W'(lowest_set(32'(viol)));
          end else if (complete) begin
            state_d = ST_PASS;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_FAIL;
            code_d  = FAIL_TIMEOUT;
            ch_d    = CH_W'(lowest_set(32'(missing)));
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      code_q  <= FAIL_NONE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ch_q    <= ch_d;
    end
  end

  assign busy_o      = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign done_o      = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass_o      = (state_q == ST_PASS);
  assign fail_o      = (state_q == ST_FAIL);
  assign fail_code_o = code_q;
  assign fail_ch_o   = ch_q;
  assign seen_o      = seen_q;
  assign cycles_o    = cnt_q;

endmodule

// File: tb/tb_k10_smoke_monitor.sv
// Runs five differently configured monitors side by side on shared stimulus and
// checks each verdict against an event-time model of the monitoring rules.
module tb_k10_smoke_monitor;

  localparam int NU = 5;
  localparam int EDGE_P[NU] = '{1, 1, 0, 0, 1};
  localparam int ORD_P[NU]  = '{0, 1, 0, 1, 0};
  localparam int STR_P[NU]  = '{0, 1, 1, 0, 0};
  localparam int TO_P[NU]   = '{50, 50, 50, 300, 300};
  localparam int NEVER      = 1000;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [7:0] mask, gp;

  logic [NU-1:0]       busy, done, pass_a, fail_a;
  logic [NU-1:0][1:0]  code_a;
  logic [NU-1:0][2:0]  ch_a;
  logic [NU-1:0][7:0]  seen_a;
  logic [31:0]         cyc_a [NU];

  int checks = 0;
  int errors = 0;
  int r_t[8], f_t[8], r2_t[8];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NU; gi++) begin : g_dut
    localparam int CW = $clog2(TO_P[gi] + 1);
    logic [CW-1:0] cyc;
    k10_smoke_monitor #(
      .NUM_CH(8), .TIMEOUT_CYCLES(TO_P[gi]), .EDGE_MODE(EDGE_P[gi]),
      .ORDERED(ORD_P[gi]), .STRICT(STR_P[gi])
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .expect_mask_i(mask), .gp_i(gp),
      .busy_o(busy[gi]), .done_o(done[gi]), .pass_o(pass_a[gi]), .fail_o(fail_a[gi]),
      .fail_code_o(code_a[gi]), .fail_ch_o(ch_a[gi]), .seen_o(seen_a[gi]), .cycles_o(cyc)
    );
    assign cyc_a[gi] = 32'(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < 8; i++) begin
      r_t[i] = NEVER; f_t[i] = NEVER; r2_t[i] = NEVER;
    end
  endtask

  // Walks RUN cycle k (0 = first cycle after ARM). A change driven just after
  // start edge + r is seen as a level from k = r+1 and as a rise at k = r+2.
  task automatic model(input int u, input logic [7:0] m, output bit ep, output logic [1:0] ec,
                       output int ech, output logic [7:0] es, output int ecyc, output int edone);
    logic [7:0] evt, newb, pend, seen;
    int viol;
    ep = 1'b1; ec = 2'b00; ech = 0; es = 8'h00; ecyc = 0; edone = 0;
    if (m == 8'h00) return;
    seen = 8'h00;
    for (int k = 0; k < TO_P[u]; k++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (EDGE_P[u] != 0)
          evt[ch] = (r_t[ch] >= 0 && k == r_t[ch] + 2) || (r2_t[ch] < NEVER && k == r2_t[ch] + 2);
        else
          evt[ch] = (k >= r_t[ch] + 1 && k <= f_t[ch]) || (k >= r2_t[ch] + 1);
      end
      newb = evt & m & ~seen;
      pend = m & ~seen & ~newb;
      ecyc = k + 1; edone = k + 2; es = seen | newb;
      if (STR_P[u] != 0 && (evt & ~m) != 8'h00) begin
        ep = 1'b0; ec = 2'b11; ech = lowest(evt & ~m); return;
      end
      viol = -1;
      if (ORD_P[u] != 0)
        for (int i = 7; i >= 0; i--)
          if (newb[i])
            for (int j = 0; j < i; j++) if (pend[j]) viol = i;
      if (viol >= 0) begin
        ep = 1'b0; ec = 2'b10; ech = viol; return;
      end
      seen = seen | newb;
      if (seen == m) return;
    end
    ep = 1'b0; ec = 2'b01; ech = lowest(m & ~seen);
  endtask

  task automatic run_scenario(input string name, input logic [7:0] m);
    bit ep[NU]; logic [1:0] ec[NU]; int ech[NU]; logic [7:0] es[NU];
    int ecyc[NU], edone[NU], donec[NU];
    int c;
    bit all_done;
    gp = 8'h00;
    for (int ch = 0; ch < 8; ch++) if (r_t[ch] < 0) gp[ch] = 1'b1;
    repeat (4) tick();
    for (int u = 0; u < NU; u++) begin
      model(u, m, ep[u], ec[u], ech[u], es[u], ecyc[u], edone[u]);
      donec[u] = -1;
    end
    mask = m; start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (m != 8'h00 && (busy[u] !== 1'b1 || seen_a[u] !== 8'h00 || cyc_a[u] !== 0)) begin
        errors++;
        $display("FAIL %s arm u%0d: busy=%b seen=%h cyc=%0d, want busy=1 seen=00 cyc=0",
                 name, u, busy[u], seen_a[u], cyc_a[u]);
      end
    end
    while (c < 400) begin
      all_done = 1'b1;
      for (int u = 0; u < NU; u++) begin
        if (donec[u] < 0 && done[u] === 1'b1) donec[u] = c;
        if (donec[u] < 0) all_done = 1'b0;
      end
      if (all_done) break;
      for (int ch = 0; ch < 8; ch++) begin
        if (r_t[ch] == c || r2_t[ch] == c) gp[ch] = 1'b1;
        if (f_t[ch] == c) gp[ch] = 1'b0;
      end
      tick();
      c++;
    end
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (donec[u] !== edone[u] || pass_a[u] !== ep[u] || fail_a[u] !== !ep[u] ||
          code_a[u] !== ec[u] || ch_a[u] !== 3'(ech[u]) || seen_a[u] !== es[u] ||
          cyc_a[u] !== ecyc[u]) begin
        errors++;
        $display("FAIL %s u%0d: done@%0d pass=%b fail=%b code=%b ch=%0d seen=%h cyc=%0d; want done@%0d pass=%b code=%b ch=%0d seen=%h cyc=%0d",
                 name, u, donec[u], pass_a[u], fail_a[u], code_a[u], ch_a[u], seen_a[u], cyc_a[u],
                 edone[u], ep[u], ec[u], ech[u], es[u], ecyc[u]);
      end else begin
        $display("%s u%0d: mask=%h pass=%b code=%b ch=%0d seen=%h cycles=%0d done@%0d",
                 name, u, m, pass_a[u], code_a[u], ch_a[u], seen_a[u], cyc_a[u], donec[u]);
      end
    end
    gp = 8'h00;
    tick();
  endtask

  task automatic check_all_zero(input string name);
    for (int u = 0; u < NU; u++) begin
      checks++;
      if ({busy[u], done[u], pass_a[u], fail_a[u], code_a[u], ch_a[u], seen_a[u]} !== '0 || cyc_a[u] !== 0) begin
        errors++;
        $display("FAIL %s u%0d: busy=%b done=%b pass=%b fail=%b code=%b ch=%0d seen=%h cyc=%0d, want all 0",
                 name, u, busy[u], done[u], pass_a[u], fail_a[u], code_a[u], ch_a[u], seen_a[u], cyc_a[u]);
      end
    end
    $display("%s: outputs checked for zero", name);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; mask = 8'h00; gp = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");
  endtask

  task automatic test_single_pass();
    clear_stim(); r_t[1] = 100;
    run_scenario("single_pass", 8'h02);
  endtask

  task automatic test_timeout();
    clear_stim(); r_t[1] = 5;
    run_scenario("timeout", 8'h06);
  endtask

  task automatic test_order();
    clear_stim(); r_t[3] = 5; r_t[1] = 15; r_t[2] = 15;
    run_scenario("order_bad", 8'h0E);
    clear_stim(); r_t[1] = 5; r_t[2] = 5; r_t[3] = 12;
    run_scenario("order_good", 8'h0E);
  endtask

  task automatic test_strict();
    clear_stim(); r_t[5] = 3; f_t[5] = 8; r_t[0] = 20;
    run_scenario("strict", 8'h01);
  endtask

  task automatic test_edge_held();
    clear_stim(); r_t[0] = -8; f_t[0] = 10; r2_t[0] = 20;
    run_scenario("edge_held", 8'h01);
  endtask

  task automatic test_empty_mask();
    clear_stim();
    run_scenario("empty_mask", 8'h00);
  endtask

  task automatic run_then_interrupt(input bit use_rst);
    gp = 8'h00; mask = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) gp[0] = 1'b1;
      tick();
    end
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (busy[u] !== 1'b1 || seen_a[u] !== 8'h01) begin
        errors++;
        $display("FAIL mid_run u%0d: busy=%b seen=%h, want busy=1 seen=01", u, busy[u], seen_a[u]);
      end
    end
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0; gp = 8'h00;
  endtask

  task automatic test_abort();
    run_then_interrupt(1'b0);
    check_all_zero("abort");
    abort = 1'b1; start = 1'b1; mask = 8'h01;
    tick();
    abort = 1'b0; start = 1'b0;
    check_all_zero("abort_over_start");
  endtask

  task automatic test_reset_mid_run();
    run_then_interrupt(1'b1);
    check_all_zero("reset_mid_run");
  endtask

  task automatic test_random();
    logic [7:0] m;
    int sel;
    for (int it = 0; it < 20; it++) begin
      clear_stim();
      m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      for (int ch = 0; ch < 8; ch++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
          r_t[ch] = -8;
          f_t[ch] = ($urandom_range(0, 1) == 0) ? NEVER : $urandom_range(0, 30);
        end else if (sel >= 3) begin
          r_t[ch] = $urandom_range(0, 60);
          f_t[ch] = ($urandom_range(0, 1) == 0) ? NEVER : r_t[ch] + $urandom_range(1, 20);
        end
      end
      run_scenario($sformatf("random%0d", it), m);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_timeout();
    test_order();
    test_strict();
    test_edge_held();
    test_empty_mask();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
